// File: rtl/video_out_load.sv
// Wishbone frame fetcher: reads one frame from RAM in NB_PACK-word bursts into the
// video output FIFO, re-reading the same frame until a new base address is posted.
module video_out_load #(
    parameter int p_WIDTH  = 640,
    parameter int p_HEIGHT = 480,
    parameter int NB_PACK  = 16
) (
    input  logic        clk,
    input  logic        RST,
    input  logic [31:0] wb_reg_ctr,
    input  logic [31:0] wb_reg_data,
    input  logic        fifo_space,
    output logic [31:0] fifo_data,
    output logic        fifo_we,
    output logic        interrupt,
    output logic        bus_err,
    output logic        p_wb_STB_O,
    output logic        p_wb_CYC_O,
    output logic        p_wb_LOCK_O,
    output logic        p_wb_WE_O,
    output logic [3:0]  p_wb_SEL_O,
    output logic [31:0] p_wb_ADR_O,
    input  logic [31:0] p_wb_DAT_I,
    input  logic        p_wb_ACK_I,
    input  logic        p_wb_ERR_I
);
    localparam int FRAME_WORDS = p_WIDTH * p_HEIGHT / 4;
    localparam int WIDX_W      = ($clog2(FRAME_WORDS) > 17) ? $clog2(FRAME_WORDS) : 17;
    localparam int BCNT_W      = $clog2(NB_PACK + 1);
    localparam logic [WIDX_W-1:0] LAST_IDX = WIDX_W'(FRAME_WORDS - 1);

    typedef enum logic [2:0] {
        WAIT_ADDR,
        WAIT_SPACE,
        READ,
        PUSH,
        FRAME_DONE
    } state_t;

    state_t              state;
    logic                ctr0_p1;
    logic                new_addr;
    logic [31:0]         new_base;
    logic [31:0]         base;
    logic [31:0]         pend_base;
    logic                pend_vld;
    logic [WIDX_W-1:0]   word_idx;
    logic [BCNT_W-1:0]   burst_cnt;
    logic [1:0]          done_cnt;
    logic                unused_bits;

    assign new_addr    = wb_reg_ctr[0] & ~ctr0_p1;
    assign new_base    = {wb_reg_data[31:2], 2'b00};
    assign p_wb_SEL_O  = 4'hF;
    assign p_wb_WE_O   = 1'b0;
    assign unused_bits = ^{wb_reg_ctr[31:1], wb_reg_data[1:0]};

    function automatic logic [31:0] word_addr(input logic [31:0] b,
                                              input logic [WIDX_W-1:0] idx);
        return b + {{(30-WIDX_W){1'b0}}, idx, 2'b00};
    endfunction

    always_ff @(posedge clk) begin
        if (RST) begin
            state       <= WAIT_ADDR;
            ctr0_p1     <= 1'b0;
            base        <= '0;
            pend_base   <= '0;
            pend_vld    <= 1'b0;
            word_idx    <= '0;
            burst_cnt   <= '0;
            done_cnt    <= '0;
            p_wb_STB_O  <= 1'b0;
            p_wb_CYC_O  <= 1'b0;
            p_wb_LOCK_O <= 1'b0;
            p_wb_ADR_O  <= '0;
            fifo_data   <= '0;
            fifo_we     <= 1'b0;
            interrupt   <= 1'b0;
            bus_err     <= 1'b0;
        end else begin
            ctr0_p1 <= wb_reg_ctr[0];
            fifo_we <= 1'b0;
            bus_err <= 1'b0;

            // A base posted while a frame is running only takes effect at the frame boundary.
            if (new_addr && state != WAIT_ADDR) begin
                pend_base <= new_base;
                pend_vld  <= 1'b1;
            end

            case (state)
                WAIT_ADDR: begin
                    if (new_addr) begin
                        base     <= new_base;
                        word_idx <= '0;
                        state    <= WAIT_SPACE;
                    end
                end

                WAIT_SPACE: begin
                    burst_cnt <= BCNT_W'(NB_PACK);
                    if (fifo_space) begin
                        p_wb_STB_O  <= 1'b1;
                        p_wb_CYC_O  <= 1'b1;
                        p_wb_LOCK_O <= 1'b1;
                        p_wb_ADR_O  <= word_addr(base, word_idx);
                        state       <= READ;
                    end
                end

                READ: begin
                    // An errored word is replaced by zero so the FIFO stays pixel-aligned.
                    if (p_wb_ERR_I || p_wb_ACK_I) begin
                        fifo_data  <= p_wb_ERR_I ? 32'h0 : p_wb_DAT_I;
                        fifo_we    <= 1'b1;
                        bus_err    <= p_wb_ERR_I;
                        p_wb_STB_O <= 1'b0;
                        state      <= PUSH;
                    end
                end

                PUSH: begin
                    word_idx  <= word_idx + WIDX_W'(1);
                    burst_cnt <= burst_cnt - BCNT_W'(1);
                    if (word_idx == LAST_IDX) begin
                        p_wb_CYC_O  <= 1'b0;
                        p_wb_LOCK_O <= 1'b0;
                        interrupt   <= 1'b1;
                        done_cnt    <= '0;
                        state       <= FRAME_DONE;
                    end else if (burst_cnt == BCNT_W'(1)) begin
                        p_wb_CYC_O  <= 1'b0;
                        p_wb_LOCK_O <= 1'b0;
                        state       <= WAIT_SPACE;
                    end else begin
                        p_wb_STB_O <= 1'b1;
                        p_wb_ADR_O <= word_addr(base, word_idx + WIDX_W'(1));
                        state      <= READ;
                    end
                end

                FRAME_DONE: begin
                    done_cnt <= done_cnt + 2'd1;
                    if (done_cnt == 2'd2) begin
                        interrupt <= 1'b0;
                        word_idx  <= '0;
                        pend_vld  <= 1'b0;
                        state     <= WAIT_SPACE;
                        if (new_addr)
                            base <= new_base;
                        else if (pend_vld)
                            base <= pend_base;
                    end
                end

                default: state <= WAIT_ADDR;
            endcase
        end
    end
endmodule
